// File: rtl/seg7_scan_driver_pkg.sv
// Shared display package.
// Holds the glyph codes the display-select stage uses to build its 16-bit
// display words, the active-low segment table, the "all off" constants and
// a small anode helper.
package seg7_scan_driver_pkg;

  // Glyph codes, one per nibble of a display word
  localparam logic [3:0] GLYPH_0     = 4'h0;
  localparam logic [3:0] GLYPH_1     = 4'h1;
  localparam logic [3:0] GLYPH_2     = 4'h2;
  localparam logic [3:0] GLYPH_3     = 4'h3;
  localparam logic [3:0] GLYPH_4     = 4'h4;
  localparam logic [3:0] GLYPH_5     = 4'h5;
  localparam logic [3:0] GLYPH_6     = 4'h6;
  localparam logic [3:0] GLYPH_7     = 4'h7;
  localparam logic [3:0] GLYPH_8     = 4'h8;
  localparam logic [3:0] GLYPH_9     = 4'h9;
  localparam logic [3:0] GLYPH_A     = 4'hA;
  localparam logic [3:0] GLYPH_B     = 4'hB;
  localparam logic [3:0] GLYPH_C     = 4'hC;
  localparam logic [3:0] GLYPH_D     = 4'hD;
  localparam logic [3:0] GLYPH_E     = 4'hE;
  localparam logic [3:0] GLYPH_BLANK = 4'hF;

  // Everything dark (both buses are active low)
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; element [k] is the pattern for glyph code k
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1111111,  // F: blank
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Active-low one-hot anode pattern selecting digit idx
  function automatic logic [3:0] onehot_low(input logic [1:0] idx);
    onehot_low = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_glyph_decode.sv
// hex_glyph_decode: combinational glyph-to-segment decoder.
// Ports:
//   code  in  4  glyph code (F is blank)
//   seg   out 7  segments {g,f,e,d,c,b,a}, active low
module hex_glyph_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Table lookup; all 16 codes are defined so no fallback is needed
  always_comb begin
    seg = SEG_TABLE[code];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. The display word and decimal points are latched once
// per frame (tear-free), digits are scanned one slot each with a short
// all-anodes-off gap at the start of every slot, and digits can blink.
// Ports:
//   clk        in  1   system clock
//   rst_n      in  1   asynchronous active-low reset
//   disp_word  in  16  glyph codes {d3,d2,d1,d0}, d0 rightmost
//   dp_in      in  4   decimal point per digit, active high
//   blink_mask in  4   digit i blinks when bit i is set (sampled live)
//   an         out 4   anode enables, active low
//   seg        out 7   segments {g,f,e,d,c,b,a}, active low
//   dp         out 1   decimal point, active low
//   frame_tick out 1   one-cycle pulse at each frame boundary
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int BLINK_FRAMES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] disp_word,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc_r, presc_nxt_s;
  logic [1:0]    idx_r, idx_nxt_s;
  logic [BW-1:0] blink_cnt_r, blink_cnt_nxt_s;
  logic          blink_hidden_r, blink_hidden_nxt_s;
  logic [15:0]   shadow_word_r, shadow_word_nxt_s;
  logic [3:0]    shadow_dp_r, shadow_dp_nxt_s;
  logic [3:0]    an_r, an_nxt_s;
  logic [6:0]    seg_r, seg_nxt_s;
  logic          dp_r, dp_nxt_s;
  logic          frame_tick_r;
  logic          wrap_s, frame_s;
  logic [3:0]    nibble_s;
  logic [6:0]    seg_dec_s;

  assign wrap_s  = (presc_r == PRESC_LAST);
  assign frame_s = wrap_s && (idx_r == 2'd3);

  // Next scan position, frame-boundary latch and blink timing
  always_comb begin
    presc_nxt_s        = presc_r;
    idx_nxt_s          = idx_r;
    shadow_word_nxt_s  = shadow_word_r;
    shadow_dp_nxt_s    = shadow_dp_r;
    blink_cnt_nxt_s    = blink_cnt_r;
    blink_hidden_nxt_s = blink_hidden_r;
    if (wrap_s) begin
      presc_nxt_s = '0;
      idx_nxt_s   = idx_r + 2'd1;
    end else begin
      presc_nxt_s = presc_r + PW'(1);
      idx_nxt_s   = idx_r;
    end
    if (frame_s) begin
      shadow_word_nxt_s = disp_word;
      shadow_dp_nxt_s   = dp_in;
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_nxt_s    = '0;
        blink_hidden_nxt_s = ~blink_hidden_r;
      end else begin
        blink_cnt_nxt_s    = blink_cnt_r + BW'(1);
        blink_hidden_nxt_s = blink_hidden_r;
      end
    end else begin
      shadow_word_nxt_s  = shadow_word_r;
      shadow_dp_nxt_s    = shadow_dp_r;
      blink_cnt_nxt_s    = blink_cnt_r;
      blink_hidden_nxt_s = blink_hidden_r;
    end
  end

  // Outputs are computed from next state so the registered pins line up
  // with the prescaler/index they belong to (no one-cycle lag).
  assign nibble_s = shadow_word_nxt_s[{idx_nxt_s, 2'b00} +: 4];

  hex_glyph_decode u_decode (
    .code (nibble_s),
    .seg  (seg_dec_s)
  );

  // Output selection: anti-ghost gap, blink suppression, digit drive
  always_comb begin
    an_nxt_s  = AN_OFF;
    seg_nxt_s = seg_r;
    dp_nxt_s  = dp_r;
    if (presc_nxt_s < BLANK_END) begin
      // Anodes off first so the segment change is never visible
      an_nxt_s  = AN_OFF;
      seg_nxt_s = seg_r;
      dp_nxt_s  = dp_r;
    end else begin
      seg_nxt_s = seg_dec_s;
      dp_nxt_s  = ~shadow_dp_nxt_s[idx_nxt_s];
      if (blink_hidden_nxt_s && blink_mask[idx_nxt_s]) begin
        an_nxt_s = AN_OFF;
      end else begin
        an_nxt_s = onehot_low(idx_nxt_s);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r        <= '0;
      idx_r          <= 2'd0;
      blink_cnt_r    <= '0;
      blink_hidden_r <= 1'b0;
      shadow_word_r  <= 16'hFFFF;
      shadow_dp_r    <= 4'b0000;
      an_r           <= AN_OFF;
      seg_r          <= SEG_OFF;
      dp_r           <= 1'b1;
      frame_tick_r   <= 1'b0;
    end else begin
      presc_r        <= presc_nxt_s;
      idx_r          <= idx_nxt_s;
      blink_cnt_r    <= blink_cnt_nxt_s;
      blink_hidden_r <= blink_hidden_nxt_s;
      shadow_word_r  <= shadow_word_nxt_s;
      shadow_dp_r    <= shadow_dp_nxt_s;
      an_r           <= an_nxt_s;
      seg_r          <= seg_nxt_s;
      dp_r           <= dp_nxt_s;
      frame_tick_r   <= frame_s;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign frame_tick = frame_tick_r;

endmodule
